// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Detects load-use hazards between decode and execute and arbitrates the shared
// memory port between fetch and the memory stage. Drives the PC/FD write enables,
// DE bubble insertion and FD/DE flushes on taken branches. Keeps saturating stall
// and flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow, memory port free unless MemReq this cycle
// MEM_HOLD | multi-cycle memory access in progress, memory stage owns port

module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W      = 3,
    parameter int MEM_HOLD_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic [REG_ADDR_W-1:0] DecSrc1,
    input  logic                  DecSrc1Valid,
    input  logic [REG_ADDR_W-1:0] DecSrc2,
    input  logic                  DecSrc2Valid,
    input  logic                  ExMemRead,
    input  logic                  ExRegWrite,
    input  logic [REG_ADDR_W-1:0] ExRegDest,
    input  logic                  MemReq,
    input  logic                  MemMultiCycle,
    input  logic                  BranchTaken,
    input  logic                  CntClr,
    output logic                  PcWriteEn,
    output logic                  FDWriteEn,
    output logic                  DEBubble,
    output logic                  FDFlush,
    output logic                  DEFlush,
    output logic                  MemGrant,
    output logic                  FetchGrant,
    output logic                  CtrlState,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_HOLD = 1'b1;

    // Wide enough to hold MEM_HOLD_CYCLES-1 for any legal value (>=1).
    localparam int HOLD_W = $clog2(MEM_HOLD_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MEM_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic load_use;
    logic stall;

    // Hazard detection and memory-port ownership, zero latency.
    always_comb begin
        mem_busy = ((state_q == ST_RUN) & MemReq) | (state_q == ST_MEM_HOLD);
        load_use = ExMemRead & ExRegWrite &
                   ((DecSrc1Valid & (DecSrc1 == ExRegDest)) |
                    (DecSrc2Valid & (DecSrc2 == ExRegDest)));
        stall    = mem_busy | load_use;
    end

    // Pipeline control outputs; a taken branch flush dominates any stall, and
    // reset forces the pipeline into a flushed, idle state.
    always_comb begin
        PcWriteEn  = 1'b0;
        FDWriteEn  = 1'b0;
        DEBubble   = 1'b1;
        FDFlush    = 1'b1;
        DEFlush    = 1'b1;
        MemGrant   = 1'b0;
        FetchGrant = 1'b0;
        CtrlState  = 1'b0;
        if (RstN) begin
            MemGrant   = mem_busy;
            FetchGrant = ~mem_busy;
            CtrlState  = state_q[0];
            if (BranchTaken) begin
                PcWriteEn = 1'b1;
                FDWriteEn = ~mem_busy;
                DEBubble  = 1'b0;
                FDFlush   = 1'b1;
                DEFlush   = 1'b1;
            end else begin
                PcWriteEn = ~stall;
                FDWriteEn = ~stall;
                DEBubble  = stall;
                FDFlush   = 1'b0;
                DEFlush   = 1'b0;
            end
        end
    end

    // Next-state logic for the memory hold FSM and its down-counter.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (MemReq && MemMultiCycle) begin
                    state_d    = ST_MEM_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_MEM_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Saturating performance counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && !BranchTaken && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (BranchTaken && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q     <= ST_RUN;
            hold_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_HOLD_CYCLES=2 and CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.

module tb_pipeline_hazard_ctrl;

    logic       Clk;
    logic       RstN;
    logic [2:0] DecSrc1;
    logic       DecSrc1Valid;
    logic [2:0] DecSrc2;
    logic       DecSrc2Valid;
    logic       ExMemRead;
    logic       ExRegWrite;
    logic [2:0] ExRegDest;
    logic       MemReq;
    logic       MemMultiCycle;
    logic       BranchTaken;
    logic       CntClr;
    logic       PcWriteEn;
    logic       FDWriteEn;
    logic       DEBubble;
    logic       FDFlush;
    logic       DEFlush;
    logic       MemGrant;
    logic       FetchGrant;
    logic       CtrlState;
    logic [3:0] StallCount;
    logic [3:0] FlushCount;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W      (3),
        .MEM_HOLD_CYCLES (2),
        .CNT_W           (4)
    ) dut (
        .Clk           (Clk),
        .RstN          (RstN),
        .DecSrc1       (DecSrc1),
        .DecSrc1Valid  (DecSrc1Valid),
        .DecSrc2       (DecSrc2),
        .DecSrc2Valid  (DecSrc2Valid),
        .ExMemRead     (ExMemRead),
        .ExRegWrite    (ExRegWrite),
        .ExRegDest     (ExRegDest),
        .MemReq        (MemReq),
        .MemMultiCycle (MemMultiCycle),
        .BranchTaken   (BranchTaken),
        .CntClr        (CntClr),
        .PcWriteEn     (PcWriteEn),
        .FDWriteEn     (FDWriteEn),
        .DEBubble      (DEBubble),
        .FDFlush       (FDFlush),
        .DEFlush       (DEFlush),
        .MemGrant      (MemGrant),
        .FetchGrant    (FetchGrant),
        .CtrlState     (CtrlState),
        .StallCount    (StallCount),
        .FlushCount    (FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic clear_inputs();
        DecSrc1 = 3'd0; DecSrc1Valid = 1'b0;
        DecSrc2 = 3'd0; DecSrc2Valid = 1'b0;
        ExMemRead = 1'b0; ExRegWrite = 1'b0; ExRegDest = 3'd0;
        MemReq = 1'b0; MemMultiCycle = 1'b0;
        BranchTaken = 1'b0; CntClr = 1'b0;
    endtask

    initial begin
        clear_inputs();
        RstN = 1'b0;

        // Forced outputs while in reset
        #3;
        chk("rst_pcwe",   PcWriteEn,  0);
        chk("rst_fdwe",   FDWriteEn,  0);
        chk("rst_bubble", DEBubble,   1);
        chk("rst_fdfl",   FDFlush,    1);
        chk("rst_defl",   DEFlush,    1);
        chk("rst_mgnt",   MemGrant,   0);
        chk("rst_fgnt",   FetchGrant, 0);
        chk("rst_state",  CtrlState,  0);
        chk("rst_scnt",   StallCount, 0);
        chk("rst_fcnt",   FlushCount, 0);

        #9 RstN = 1'b1;
        sample();
        chk("rel_fgnt",   FetchGrant, 1);
        chk("rel_pcwe",   PcWriteEn,  1);
        chk("rel_bubble", DEBubble,   0);
        chk("rel_fdfl",   FDFlush,    0);

        // Load-use via source 2
        next_cycle();
        ExMemRead = 1; ExRegWrite = 1; ExRegDest = 3'd3;
        DecSrc1 = 3'd5; DecSrc1Valid = 1; DecSrc2 = 3'd3; DecSrc2Valid = 1;
        sample();
        chk("lu2_pcwe",   PcWriteEn, 0);
        chk("lu2_fdwe",   FDWriteEn, 0);
        chk("lu2_bubble", DEBubble,  1);
        chk("lu2_fgnt",   FetchGrant, 1);
        chk("lu2_scnt",   StallCount, 0);
        next_cycle();
        ExMemRead = 0;
        sample();
        chk("lu2_after_pcwe",   PcWriteEn, 1);
        chk("lu2_after_bubble", DEBubble,  0);
        chk("lu2_after_scnt",   StallCount, 1);

        // Load in execute but matching source not read
        next_cycle();
        ExMemRead = 1; DecSrc2Valid = 0;
        sample();
        chk("nolu_valid", PcWriteEn, 1);
        // Matching source, but execute instruction writes no register
        next_cycle();
        DecSrc2Valid = 1; ExRegWrite = 0;
        sample();
        chk("nolu_regwr", DEBubble, 0);
        // Load-use via source 1
        next_cycle();
        ExRegWrite = 1; DecSrc2Valid = 0; DecSrc1 = 3'd3;
        sample();
        chk("lu1_bubble", DEBubble, 1);
        next_cycle();
        clear_inputs();
        sample();
        chk("lu1_scnt", StallCount, 2);

        // Multi-cycle memory access: three cycles of grant
        next_cycle();
        MemReq = 1; MemMultiCycle = 1;
        sample();
        chk("mc0_mgnt",  MemGrant,   1);
        chk("mc0_fgnt",  FetchGrant, 0);
        chk("mc0_state", CtrlState,  0);
        chk("mc0_pcwe",  PcWriteEn,  0);
        next_cycle();
        MemReq = 0; MemMultiCycle = 0;
        sample();
        chk("mc1_state", CtrlState, 1);
        chk("mc1_mgnt",  MemGrant,  1);
        next_cycle();
        sample();
        chk("mc2_state", CtrlState, 1);
        chk("mc2_mgnt",  MemGrant,  1);
        next_cycle();
        sample();
        chk("mc3_state", CtrlState,  0);
        chk("mc3_mgnt",  MemGrant,   0);
        chk("mc3_fgnt",  FetchGrant, 1);
        chk("mc3_pcwe",  PcWriteEn,  1);
        chk("mc3_scnt",  StallCount, 5);

        // MemMultiCycle alone is ignored
        next_cycle();
        MemMultiCycle = 1;
        sample();
        chk("mconly_mgnt", MemGrant, 0);
        next_cycle();
        MemMultiCycle = 0;
        sample();
        chk("mconly_state", CtrlState, 0);
        chk("mconly_scnt",  StallCount, 5);

        // Single-cycle memory request
        next_cycle();
        MemReq = 1;
        sample();
        chk("sc_mgnt", MemGrant, 1);
        next_cycle();
        MemReq = 0;
        sample();
        chk("sc_state", CtrlState, 0);
        chk("sc_mgnt2", MemGrant,  0);
        chk("sc_scnt",  StallCount, 6);

        // Taken branch during MEM_HOLD: flush, hold continues
        next_cycle();
        MemReq = 1; MemMultiCycle = 1;
        next_cycle();
        MemReq = 0; MemMultiCycle = 0; BranchTaken = 1;
        sample();
        chk("brh_state",  CtrlState, 1);
        chk("brh_fdfl",   FDFlush,   1);
        chk("brh_defl",   DEFlush,   1);
        chk("brh_pcwe",   PcWriteEn, 1);
        chk("brh_fdwe",   FDWriteEn, 0);
        chk("brh_bubble", DEBubble,  0);
        chk("brh_mgnt",   MemGrant,  1);
        next_cycle();
        BranchTaken = 0;
        sample();
        chk("brh_cont_state", CtrlState, 1);
        chk("brh_fcnt",       FlushCount, 1);
        chk("brh_scnt",       StallCount, 7);
        next_cycle();
        sample();
        chk("brh_end_state", CtrlState, 0);
        chk("brh_end_scnt",  StallCount, 8);

        // Taken branch in RUN dominates a load-use stall
        next_cycle();
        BranchTaken = 1;
        ExMemRead = 1; ExRegWrite = 1; ExRegDest = 3'd4; DecSrc1 = 3'd4; DecSrc1Valid = 1;
        sample();
        chk("brr_pcwe",   PcWriteEn, 1);
        chk("brr_fdwe",   FDWriteEn, 1);
        chk("brr_bubble", DEBubble,  0);
        chk("brr_defl",   DEFlush,   1);
        next_cycle();
        clear_inputs();
        sample();
        chk("brr_fcnt", FlushCount, 2);
        chk("brr_scnt", StallCount, 8);

        // Stall counter saturation, then clear beats increment
        next_cycle();
        MemReq = 1;
        repeat (20) next_cycle();
        sample();
        chk("sat_scnt", StallCount, 15);
        next_cycle();
        CntClr = 1;
        next_cycle();
        CntClr = 0; MemReq = 0;
        sample();
        chk("clr_scnt", StallCount, 0);
        chk("clr_fcnt", FlushCount, 0);

        // Reset asserted mid-hold aborts asynchronously
        next_cycle();
        MemReq = 1; MemMultiCycle = 1;
        next_cycle();
        MemReq = 0; MemMultiCycle = 0;
        sample();
        chk("rh_state_pre", CtrlState, 1);
        #2 RstN = 1'b0;
        #1;
        chk("rh_state",  CtrlState, 0);
        chk("rh_mgnt",   MemGrant,  0);
        chk("rh_bubble", DEBubble,  1);
        #1 RstN = 1'b1;
        sample();
        chk("rh_rel_state", CtrlState,  0);
        chk("rh_rel_mgnt",  MemGrant,   0);
        chk("rh_rel_fgnt",  FetchGrant, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
